ascon128_top: RTL and testbench
===============================

// Module: ascon128_top
// PURPOSE
//  Iterative Ascon-128 AEAD encryption core, one permutation round per clock.
//  - Each run takes one 128-bit key, one 128-bit nonce, one 64-bit associated-data block and one 64-bit plaintext block.
//  - Each run produces one 64-bit ciphertext block and a 128-bit tag.
//  - Free-running: runs back to back with no handshake; top level of the lightweight encrypt path.
// PARAMETERS
//  IV       64'h80400c0600000000  Ascon-128 initial value (k=128, r=64, a=12, b=6)
//  ROUNDS_A 12                    rounds in the init and finalization permutations
//  ROUNDS_B 6                     rounds in the intermediate permutation
// PORTS
//  CLK  in   1    single clock, rising edge
//  RST  in   1    synchronous, active-high reset
//  SK   in   128  secret key K
//  N    in   128  nonce
//  A    in   64   associated-data block; caller supplies it already padded, no extra pad block is added
//  P    in   64   plaintext block; caller supplies it already padded, treated as the final block
//  C    out  64   ciphertext, registered
//  T    out  128  tag, registered
// BEHAVIOUR
//  - Reset: RST high at a rising edge forces the following.
//      fsm=LOAD, round counter=0, 320-bit state S=0, C=0, T=0.
//      Takes effect mid-run too; the run is aborted and no output updates.
//  - State layout: S = x0||x1||x2||x3||x4, 64 bits each, x0 in the MSBs; rate = x0.
//  - Round (combinational):
//      add constant: x2 ^= c.
//      5-bit Ascon S-box, bit-sliced.
//      linear layer: xi ^= (xi>>>a) ^ (xi>>>b); (a,b) = x0:(19,28) x1:(61,39) x2:(1,6) x3:(10,17) x4:(7,41).
//  - Round constants c for p12 rounds 0..11: f0 e1 d2 c3 b4 a5 96 87 78 69 5a 4b.
//  - p6 uses the last six constants (96..4b).
//  - FSM, 32 cycles per run:
//    LOAD, 1 cycle:
//      sample SK, N, A, P into internal registers; S <= IV||K||N.
//      Input changes after this cycle do not affect the run.
//    INIT, 12 cycles, one round per cycle. On the 12th round, in the same cycle:
//      S <= round(S) ^ (0^192||K);
//      then x0 ^= A.
//    AD, 6 cycles. On the 6th round, in the same cycle:
//      S <= round(S) ^ (0^319||1);
//      then x0 ^= P;
//      then capture the new x0 into an internal Creg;
//      then S ^= (0^64||K||0^128).
//    FINAL, 12 cycles. On the 12th round: Treg <= (x3||x4 of round(S)) ^ K.
//    DONE, 1 cycle: C <= Creg, T <= Treg, then go to LOAD.
//  - Outputs: C and T change only in DONE, both in the same cycle.
//      Held stable for the other 31 cycles.
//  - Latency: first results appear 32 cycles after reset release; the period is 32 cycles thereafter.
//  - Boundary cases:
//      All-zero or all-one inputs need no special handling.
//      Round counter runs 0..11 or 0..5, wraps to 0 on each state exit.
//      The round-index-to-constant mapping for p6 is offset by 6.
// STRUCTURE
//  - Shared package ascon_pkg holds:
//      IV; round-constant table (12 x 8 bit); rotation amounts;
//      FSM state encoding (LOAD, INIT, AD, FINAL, DONE).
//  - One sub-module: ascon_round.
//      Combinational; inputs S_in[319:0] and rc[7:0]; output S_out[319:0].
//  - Top: FSM, round counter, state register, K/A/P/C/T registers.
// TESTING
//  - Reset: hold RST for 3 cycles -> C=0 and T=0.
//      Release -> first C/T update exactly 32 cycles later; no change in between.
//  - Zero vector: SK=0, N=0, A=0, P=0 -> C and T equal the golden Ascon-128 C model.
//      Golden model: A and P processed as single pre-padded blocks, no extra pad.
//  - Key/nonce pattern: SK=000102..0f, N=000102..0f, A=0001020304050607, P=0001020304050607 -> C/T match golden model.
//  - Input isolation: change SK/N/A/P every cycle after LOAD -> the result matches the vector sampled at LOAD.
//      The next run uses the values present at the next LOAD.
//  - Reset mid-run: assert RST in AD state -> outputs return to 0, no stale result emitted.
//      Next result arrives 32 cycles after release.
//  - Back-to-back: apply 100 random vectors, each held for 32 cycles aligned to LOAD -> all C/T match the model.
//      Sensitivity check: flipping a single bit of P flips the same bit of C and changes T.

Source files
------------

// File: rtl/ascon_pkg.sv
// ascon_pkg: shared constants, round-constant table, rotation amounts and FSM encoding
// for the iterative Ascon-128 encryption core.
package ascon_pkg;
    localparam logic [63:0] IV = 64'h80400c0600000000;
    localparam int ROUNDS_A = 12;
    localparam int ROUNDS_B = 6;
    localparam logic [7:0] RC [12] = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
                                        8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};
    localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

    typedef enum logic [2:0] {LOAD, INIT, AD, FINAL, DONE} fsm_t;

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction
endpackage

// File: rtl/ascon_round.sv
// ascon_round: one combinational Ascon permutation round (constant, bit-sliced S-box,
// linear diffusion) on the 320-bit state, x0 in the MSBs.
module ascon_round
    import ascon_pkg::*;
(
    input  logic [319:0] S_in,
    input  logic [7:0]   rc,
    output logic [319:0] S_out
);
    logic [63:0] x [5];
    logic [63:0] a [5];
    logic [63:0] b [5];
    logic [63:0] c [5];

    assign a[0] = x[0] ^ x[4];
    assign a[1] = x[1];
    assign a[2] = x[2] ^ {56'd0, rc} ^ x[1];
    assign a[3] = x[3];
    assign a[4] = x[4] ^ x[3];

    // post-chi mixing; c[1] uses b[0] before x0 picks up x4
    assign c[0] = b[0] ^ b[4];
    assign c[1] = b[1] ^ b[0];
    assign c[2] = ~b[2];
    assign c[3] = b[3] ^ b[2];
    assign c[4] = b[4];

    for (genvar i = 0; i < 5; i++) begin : g_lane
        assign x[i] = S_in[319 - 64*i -: 64];
        assign b[i] = a[i] ^ (~a[(i + 1) % 5] & a[(i + 2) % 5]);
        assign S_out[319 - 64*i -: 64] = c[i] ^ rotr(c[i], ROT_A[i]) ^ rotr(c[i], ROT_B[i]);
    end
endmodule

// File: rtl/ascon128_top.sv
// ascon128_top: free-running Ascon-128 encryption of one AD block and one plaintext block,
// one permutation round per clock, 32 cycles per run, C/T updated together in DONE.
module ascon128_top
    import ascon_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    input  logic [127:0] SK,
    input  logic [127:0] N,
    input  logic [63:0]  A,
    input  logic [63:0]  P,
    output logic [63:0]  C,
    output logic [127:0] T
);
    fsm_t         fsm_q, fsm_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [319:0] s_q, s_d;
    logic [127:0] k_q, k_d, treg_q, treg_d, t_q, t_d;
    logic [63:0]  a_q, a_d, p_q, p_d, creg_q, creg_d, c_q, c_d;
    logic [319:0] s_r, ad_x;
    logic [3:0]   rc_idx;
    logic         last;

    // p6 runs on the tail of the p12 constant table
    assign rc_idx = (fsm_q == AD) ? cnt_q + 4'd6 : cnt_q;
    assign last   = cnt_q == ((fsm_q == AD) ? 4'd5 : 4'd11);
    assign ad_x   = s_r ^ {p_q, 255'd0, 1'b1};
    assign C      = c_q;
    assign T      = t_q;

    ascon_round u_round (
        .S_in  (s_q),
        .rc    (RC[rc_idx]),
        .S_out (s_r)
    );

    always_comb begin
        fsm_d  = fsm_q;
        s_d    = s_q;
        k_d    = k_q;
        a_d    = a_q;
        p_d    = p_q;
        creg_d = creg_q;
        treg_d = treg_q;
        c_d    = c_q;
        t_d    = t_q;
        cnt_d  = (fsm_q inside {INIT, AD, FINAL} && !last) ? cnt_q + 4'd1 : 4'd0;
        case (fsm_q)
            LOAD: begin
                k_d   = SK;
                a_d   = A;
                p_d   = P;
                s_d   = {IV, SK, N};
                fsm_d = INIT;
            end
            INIT: begin
                s_d   = last ? s_r ^ {192'd0, k_q} ^ {a_q, 256'd0} : s_r;
                fsm_d = last ? AD : INIT;
            end
            AD: begin
                s_d    = last ? ad_x ^ {64'd0, k_q, 128'd0} : s_r;
                creg_d = last ? ad_x[319:256] : creg_q;
                fsm_d  = last ? FINAL : AD;
            end
            FINAL: begin
                s_d    = s_r;
                treg_d = last ? s_r[127:0] ^ k_q : treg_q;
                fsm_d  = last ? DONE : FINAL;
            end
            DONE: begin
                c_d   = creg_q;
                t_d   = treg_q;
                fsm_d = LOAD;
            end
            default: fsm_d = LOAD;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fsm_q  <= LOAD;
            cnt_q  <= '0;
            s_q    <= '0;
            k_q    <= '0;
            a_q    <= '0;
            p_q    <= '0;
            creg_q <= '0;
            treg_q <= '0;
            c_q    <= '0;
            t_q    <= '0;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            s_q    <= s_d;
            k_q    <= k_d;
            a_q    <= a_d;
            p_q    <= p_d;
            creg_q <= creg_d;
            treg_q <= treg_d;
            c_q    <= c_d;
            t_q    <= t_d;
        end
    end
endmodule

// File: tb/tb_ascon128_top.sv
// tb_ascon128_top: scoreboard bench; a driver pushes reference C/T per run, a monitor checks
// results every 32nd cycle after reset release and holds/zeros in between.
module tb_ascon128_top;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] sk = '0, n = '0;
    logic [63:0]  a = '0, p = '0;
    logic [63:0]  c;
    logic [127:0] t;

    int errors = 0;
    int checks = 0;
    logic [191:0] exp_q [$];
    logic [63:0]  last_c = '0;
    logic [127:0] last_t = '0;

    localparam logic [4:0] SBOX [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                                         5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                                         5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                                         5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    localparam int RA [5] = '{19, 61, 1, 10, 7};
    localparam int RB [5] = '{28, 39, 6, 17, 41};

    always #5 clk = ~clk;

    ascon128_top dut (
        .CLK (clk),
        .RST (rst),
        .SK  (sk),
        .N   (n),
        .A   (a),
        .P   (p),
        .C   (c),
        .T   (t)
    );

    function automatic logic [63:0] rot(input logic [63:0] v, input int r);
        return (v >> r) | (v << (64 - r));
    endfunction

    // Ascon permutation with the last nr rounds, S-box applied column by column via table
    function automatic logic [319:0] perm(input logic [319:0] st, input int nr);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  idx, o;
        for (int j = 0; j < 5; j++) x[j] = st[319 - 64*j -: 64];
        for (int r = 12 - nr; r < 12; r++) begin
            x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
            for (int bt = 0; bt < 64; bt++) begin
                idx = {x[0][bt], x[1][bt], x[2][bt], x[3][bt], x[4][bt]};
                o = SBOX[idx];
                for (int j = 0; j < 5; j++) y[j][bt] = o[4 - j];
            end
            for (int j = 0; j < 5; j++) x[j] = y[j] ^ rot(y[j], RA[j]) ^ rot(y[j], RB[j]);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [191:0] ascon_enc(input logic [127:0] k, input logic [127:0] nn,
                                               input logic [63:0] ad, input logic [63:0] pt);
        logic [319:0] s;
        logic [63:0]  ct;
        s = perm({64'h80400c0600000000, k, nn}, 12);
        s[127:0]   = s[127:0] ^ k;
        s[319:256] = s[319:256] ^ ad;
        s = perm(s, 6);
        s[0] = ~s[0];
        s[319:256] = s[319:256] ^ pt;
        ct = s[319:256];
        s[255:128] = s[255:128] ^ k;
        s = perm(s, 12);
        return {ct, s[127:0] ^ k};
    endfunction

    // monitor: sees RST as the DUT does at the edge, checks 1 time unit later
    always begin : monitor
        static int phase = 0;
        static logic [191:0] held = '0;
        logic r;
        logic [191:0] e;
        @(posedge clk);
        r = rst;
        #1;
        checks++;
        if (r) begin
            phase = 0;
            held = '0;
            if (c !== 64'd0 || t !== 128'd0) begin
                errors++;
                $display("FAIL reset: C=%h T=%h, want zero", c, t);
            end
        end else begin
            phase++;
            if (phase == 32) begin
                phase = 0;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL result: unexpected output C=%h T=%h", c, t);
                end else begin
                    e = exp_q.pop_front();
                    held = e;
                    last_c = c;
                    last_t = t;
                    if ({c, t} !== e) begin
                        errors++;
                        $display("FAIL result: C=%h T=%h, want C=%h T=%h", c, t, e[191:128], e[127:0]);
                    end
                end
            end else if ({c, t} !== held) begin
                errors++;
                $display("FAIL hold: phase %0d C=%h T=%h, want C=%h T=%h", phase, c, t,
                         held[191:128], held[127:0]);
            end
        end
    end

    function automatic logic [127:0] r128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic scramble();
        sk = r128();
        n  = r128();
        a  = {$urandom, $urandom};
        p  = {$urandom, $urandom};
    endtask

    // called right after a negedge, so the next posedge is LOAD
    task automatic run_vec(input logic [127:0] k, input logic [127:0] nn, input logic [63:0] ad,
                           input logic [63:0] pt, input bit scr);
        sk = k;
        n  = nn;
        a  = ad;
        p  = pt;
        exp_q.push_back(ascon_enc(k, nn, ad, pt));
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (scr && i < 31) scramble();
        end
    endtask

    initial begin : driver
        logic [127:0] k, nn, t1;
        logic [63:0]  ad, pt, c1, msk;
        do_reset();
        run_vec('0, '0, '0, '0, 1'b0);
        run_vec(128'h000102030405060708090a0b0c0d0e0f, 128'h000102030405060708090a0b0c0d0e0f,
                64'h0001020304050607, 64'h0001020304050607, 1'b0);
        run_vec({128{1'b1}}, {128{1'b1}}, {64{1'b1}}, {64{1'b1}}, 1'b0);
        run_vec(r128(), r128(), {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        run_vec(r128(), r128(), {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        // abort a run in the AD phase; nothing may be emitted for it
        scramble();
        repeat (15) @(negedge clk);
        do_reset();
        run_vec(r128(), r128(), {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        for (int i = 0; i < 100; i++)
            run_vec(r128(), r128(), {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        k = r128(); nn = r128(); ad = {$urandom, $urandom}; pt = {$urandom, $urandom};
        msk = 64'd1 << $urandom_range(63, 0);
        run_vec(k, nn, ad, pt, 1'b0);
        c1 = last_c;
        t1 = last_t;
        run_vec(k, nn, ad, pt ^ msk, 1'b0);
        checks++;
        if ((c1 ^ last_c) !== msk) begin
            errors++;
            $display("FAIL sens_c: C diff=%h, want %h", c1 ^ last_c, msk);
        end
        checks++;
        if (t1 === last_t) begin
            errors++;
            $display("FAIL sens_t: T=%h unchanged, want a different tag", last_t);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results pending, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
